// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_W           = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Power-of-2 synchronous FIFO with combinational head output (zero when empty).
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             full, push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign pop_ok  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction prefetcher with redirect/flush handling.
// Optional perf counters (stall_cycles, redirect_count) under FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);
  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_pc, rsp_pc;
  logic [2*INST_W-1:0] head;
  logic [CW-1:0] discard_cnt, discard_nxt, tag_cnt, fifo_cnt;
  logic [CW-1:0] outstanding, out_nxt, fifo_nxt;
  logic tag_empty, fifo_empty, req_acc, rsp_take, rsp_keep, push, pop;

  assign mem_req_valid = !rst && (state == FETCH);
  assign mem_req_addr  = fetch_pc;
  assign req_acc       = mem_req_valid && mem_req_ready;
  assign rsp_take      = mem_rsp_valid && !tag_empty;
  assign rsp_keep      = rsp_take && (discard_cnt == '0);
  assign push          = rsp_keep && !redirect_valid;
  assign pop           = inst_valid && inst_ready && !redirect_valid;
  // tag queue holds every in-flight request, discarded ones included
  assign outstanding   = tag_cnt - discard_cnt;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INST_W)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_acc),
    .push_data (fetch_pc),
    .pop       (rsp_take),
    .head_data (rsp_pc),
    .empty     (tag_empty),
    .count     (tag_cnt)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2*INST_W)) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = head[2*INST_W-1:INST_W];
  assign inst_data  = head[INST_W-1:0];

  always_comb begin
    fifo_nxt    = fifo_cnt;
    out_nxt     = outstanding;
    discard_nxt = discard_cnt;
    state_nxt   = state;
    if (redirect_valid) begin
      fifo_nxt    = '0;
      out_nxt     = '0;
      discard_nxt = tag_cnt + (req_acc ? ONE : '0) - (rsp_take ? ONE : '0);
    end else begin
      fifo_nxt = fifo_cnt + (push ? ONE : '0) - (pop ? ONE : '0);
      out_nxt  = outstanding + (req_acc ? ONE : '0) - (rsp_keep ? ONE : '0);
      if (rsp_take && discard_cnt != '0) discard_nxt = discard_cnt - ONE;
    end
    if (discard_nxt != '0)
      state_nxt = FLUSH;
    else if ({1'b0, fifo_nxt} + {1'b0, out_nxt} >= DEPTH_W)
      state_nxt = STALL;
    else
      state_nxt = FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
      if (redirect_valid)
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (req_acc)
        fetch_pc <= fetch_pc + 32'd4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if ((state == STALL || state == FLUSH) && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_valid && redirect_count != '1)
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit with a queue-based memory and stream model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int rdy_mode, irdy_mode, lat_min, lat_max;
  // stream model: what the consumer should see, derived from fetch order rules
  logic [31:0] exp_req, exp_del, prev_addr, last_acc_addr, first_pop_pc;
  int discard_m, live, fifo_m, n_acc, n_pop;
  bit hold_pend, got_first, saw_wrap;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_req = RPC; exp_del = RPC;
    discard_m = 0; live = 0; fifo_m = 0; n_acc = 0; n_pop = 0;
    hold_pend = 0; got_first = 0; saw_wrap = 0; last_acc_addr = 32'h1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_req_ready = 1'b0; inst_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got rv=%b iv=%b data=%h pc=%h expected 0 0 0 0",
               mem_req_valid, inst_valid, inst_data, inst_pc);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc);
    bit acc, pop, rsp, exp_rv;
    mem_req_ready  = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
    inst_ready     = (irdy_mode == 2) ? 1'($urandom_range(0, 1)) : (irdy_mode != 0);
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? mdata(mq[0].addr) : $urandom;
    #1;
    exp_rv = (discard_m == 0) && (live < DEPTH);
    checks++;
    if (mem_req_valid !== exp_rv) begin
      failures++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, mem_req_valid, exp_rv);
    end
    checks++;
    if (inst_valid !== (fifo_m > 0)) begin
      failures++;
      $display("FAIL inst_valid cyc=%0d: got %b expected %b", cyc, inst_valid, fifo_m > 0);
    end
    if (hold_pend) begin
      checks++;
      if (mem_req_addr !== prev_addr) begin
        failures++;
        $display("FAIL addr_hold cyc=%0d: got %h expected %h", cyc, mem_req_addr, prev_addr);
      end
    end
    acc = mem_req_valid && mem_req_ready;
    pop = inst_valid && inst_ready && !redir;
    if (acc) begin
      checks++;
      if (mem_req_addr !== exp_req) begin
        failures++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, mem_req_addr, exp_req);
      end
      if (last_acc_addr == 32'hFFFF_FFFC && mem_req_addr == 32'h0) saw_wrap = 1;
      last_acc_addr = mem_req_addr;
      exp_req += 32'd4;
      mq.push_back('{mem_req_addr, cyc + $urandom_range(lat_min, lat_max)});
      live++; n_acc++;
    end
    if (pop) begin
      checks++;
      if (inst_pc !== exp_del || inst_data !== mdata(exp_del)) begin
        failures++;
        $display("FAIL inst_out cyc=%0d: got pc=%h data=%h expected pc=%h data=%h",
                 cyc, inst_pc, inst_data, exp_del, mdata(exp_del));
      end
      if (!got_first) begin got_first = 1; first_pop_pc = inst_pc; end
      exp_del += 32'd4;
      live--; fifo_m--; n_pop++;
    end
    if (rsp) begin
      void'(mq.pop_front());
      if (discard_m > 0) discard_m--;
      else if (!redir) fifo_m++;
    end
    if (redir) begin
      discard_m = mq.size();
      exp_req = rpc & 32'hFFFF_FFFC;
      exp_del = rpc & 32'hFFFF_FFFC;
      live = 0; fifo_m = 0; got_first = 0;
    end
    hold_pend = mem_req_valid && !mem_req_ready && !redir;
    prev_addr = mem_req_addr;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    rdy_mode = 1; irdy_mode = 1; lat_min = 1; lat_max = 1;
    step(0, '0);
    checks++;
    if (n_acc !== 1) begin
      failures++;
      $display("FAIL reset_first_fetch: got %0d accepts expected 1", n_acc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    rdy_mode = 1; irdy_mode = 1; lat_min = 1; lat_max = 1;
    repeat (30) step(0, '0);
    checks++;
    if (n_pop < 20 || first_pop_pc !== 32'h0) begin
      failures++;
      $display("FAIL stream: got pops=%0d first=%h expected >=20 first=0", n_pop, first_pop_pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    rdy_mode = 1; irdy_mode = 0; lat_min = 1; lat_max = 1;
    repeat (20) step(0, '0);
    checks++;
    if (n_acc !== 4 || mem_req_valid !== 1'b0 || dut.state !== STALL) begin
      failures++;
      $display("FAIL stall: got acc=%0d rv=%b state=%0d expected 4 0 %0d",
               n_acc, mem_req_valid, dut.state, STALL);
    end
    irdy_mode = 1;
    repeat (4) step(0, '0);
    checks++;
    if (n_pop !== 4) begin
      failures++;
      $display("FAIL stall_drain: got %0d pops expected 4", n_pop);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    rdy_mode = 1; irdy_mode = 1; lat_min = 4; lat_max = 4;
    repeat (2) step(0, '0);
    rdy_mode = 0;
    step(1, 32'h100);
    checks++;
    if (discard_m !== 2) begin
      failures++;
      $display("FAIL redirect_discard: got %0d pending expected 2", discard_m);
    end
    rdy_mode = 1; lat_min = 1; lat_max = 1;
    repeat (12) step(0, '0);
    checks++;
    if (!got_first || first_pop_pc !== 32'h100) begin
      failures++;
      $display("FAIL redirect_first_pc: got %h (seen=%0d) expected 00000100", first_pop_pc, got_first);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rdy_mode = 1; irdy_mode = 1; lat_min = 1; lat_max = 2;
    step(1, 32'hFFFF_FFF6);
    repeat (10) step(0, '0);
    checks++;
    if (!saw_wrap) begin
      failures++;
      $display("FAIL pc_wrap: got no 0 after FFFFFFFC (last=%h) expected wrap", last_acc_addr);
    end
  endtask

  task automatic test_random();
    int pops0;
    do_reset();
    rdy_mode = 2; irdy_mode = 2; lat_min = 1; lat_max = 3;
    pops0 = 0;
    for (int i = 0; i < 500; i++) begin
      pops0 += 0;
      if ($urandom_range(0, 99) < 4) step(1, $urandom);
      else step(0, '0);
    end
    checks++;
    if (n_pop < 50) begin
      failures++;
      $display("FAIL random_progress: got %0d pops expected >=50", n_pop);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    rdy_mode = 1; irdy_mode = 0; lat_min = 6; lat_max = 6;
    repeat (3) step(0, '0);
    checks++;
    if (n_acc !== 3) begin
      failures++;
      $display("FAIL inflight_setup: got %0d accepts expected 3", n_acc);
    end
    do_reset();
    rdy_mode = 1; irdy_mode = 1; lat_min = 1; lat_max = 1;
    step(0, '0);
    checks++;
    if (n_acc !== 1 || fifo_m !== 0) begin
      failures++;
      $display("FAIL inflight_refetch: got acc=%0d fifo=%0d expected 1 0", n_acc, fifo_m);
    end
    repeat (6) step(0, '0);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_req_ready = 1'b0; inst_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
